// File: rtl/kyber_pkg.sv
// Shared Kyber constants, encoder state encoding and the 3-byte beat payload.
package kyber_pkg;

    localparam int unsigned KYBER_N        = 256;
    localparam int unsigned KYBER_Q        = 3329;
    localparam int unsigned COEFF_WIDTH    = 16;
    localparam int unsigned COEFF_BITS     = 12;
    localparam int unsigned BYTES_PER_POLY = 384;
    localparam int unsigned BEATS          = KYBER_N / 2;
    localparam int unsigned PAIR_W         = 7;
    localparam int unsigned POLY_W         = KYBER_N * COEFF_WIDTH;
    localparam int unsigned BEAT_W         = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    // b0 is earliest in stream order and sits in the top byte of the beat.
    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } beat_t;

endpackage

// File: rtl/kyber_csubq.sv
// Single conditional subtraction of Q with 12-bit result.
// Ports:
//   coeff_i     16-bit stored coefficient
//   coeff_o     reduced 12-bit coefficient
//   range_err_o input was >= 2Q (result is (x-Q) truncated to 12 bits)
module kyber_csubq
    import kyber_pkg::*;
(
    input  logic [COEFF_WIDTH-1:0] coeff_i,
    output logic [COEFF_BITS-1:0]  coeff_o,
    output logic                   range_err_o
);

    logic [COEFF_WIDTH-1:0] diff;

    assign diff = coeff_i - COEFF_WIDTH'(KYBER_Q);

    always_comb begin
        coeff_o     = coeff_i[COEFF_BITS-1:0];
        range_err_o = 1'b0;
        if (coeff_i >= COEFF_WIDTH'(KYBER_Q)) begin
            coeff_o     = diff[COEFF_BITS-1:0];
            range_err_o = (coeff_i >= COEFF_WIDTH'(2 * KYBER_Q));
        end
    end

endmodule

// File: rtl/poly_byte_encode12.sv
// ByteEncode_12 serialiser: 256 coefficients -> 128 beats of 3 bytes.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       latch poly_in and begin (honoured only in IDLE)
//   poly_in     coefficient k at [k*16 +: 16]
//   out_data    {byte0, byte1, byte2}, registered
//   out_valid   out_data holds a beat; out_ready accepts it
//   out_last    beat 127 is presented
//   busy        encoding in progress
//   done        one-cycle pulse after the final acceptance
//   range_err   sticky, some presented coefficient was >= 2Q
module poly_byte_encode12
    import kyber_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [POLY_W-1:0] poly_in,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(BEATS - 1);

    enc_state_e        state_q, state_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic [POLY_W-1:0] poly_q, poly_d;
    beat_t             beat_q, beat_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic                   use_in;
    logic [PAIR_W-1:0]      sel_pair;
    logic [11:0]            base_a, base_b;
    logic [COEFF_WIDTH-1:0] raw_a, raw_b;
    logic [COEFF_BITS-1:0]  red_a, red_b;
    logic                   err_a, err_b;
    logic                   accept;

    assign accept = valid_q & out_ready;

    // Beat 0 comes straight from poly_in at start; later beats from the latched copy.
    assign base_a = {sel_pair, 5'b00000};
    assign base_b = {sel_pair, 5'b10000};
    assign raw_a  = use_in ? poly_in[COEFF_WIDTH-1:0]             : poly_q[base_a +: COEFF_WIDTH];
    assign raw_b  = use_in ? poly_in[2*COEFF_WIDTH-1:COEFF_WIDTH] : poly_q[base_b +: COEFF_WIDTH];

    kyber_csubq u_csub_a (
        .coeff_i     (raw_a),
        .coeff_o     (red_a),
        .range_err_o (err_a)
    );

    kyber_csubq u_csub_b (
        .coeff_i     (raw_b),
        .coeff_o     (red_b),
        .range_err_o (err_b)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        poly_d   = poly_q;
        beat_d   = beat_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        use_in   = 1'b0;
        sel_pair = pair_q + PAIR_W'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    use_in  = 1'b1;
                    state_d = SEND;
                    pair_d  = '0;
                    poly_d  = poly_in;
                    beat_d  = '{b0: red_a[7:0], b1: {red_b[3:0], red_a[11:8]}, b2: red_b[11:4]};
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = err_a | err_b;
                end
            end
            SEND: begin
                if (accept) begin
                    if (pair_q == LAST_PAIR) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pair_d  = sel_pair;
                        beat_d  = '{b0: red_a[7:0], b1: {red_b[3:0], red_a[11:8]}, b2: red_b[11:4]};
                        last_d  = (sel_pair == LAST_PAIR);
                        err_d   = err_q | err_a | err_b;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pair_q  <= '0;
            poly_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            poly_q  <= poly_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_data  = beat_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign range_err = err_q;

endmodule
